// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for the 16-bit CPU: sequences fetch/decode/execute with memory
// handshakes, a multi-cycle ALU and HALT/illegal handling. Optional counters: CPU_CTRL_PERF_EN.
module cpu_ctrl_fsm #(
    parameter int IW         = 16,
    parameter int OPW        = 5,
    parameter int ALU_CYCLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             start,
    input  logic [IW-1:0]    opcode,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IR_EN,
    output logic             PC_EN,
    output logic             MDR_EN,
    output logic             BR_EN,
    output logic             RFwrite,
    output logic             LDW_EN,
    output logic             dataW_MDR,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);
    // state   | meaning
    // IDLE    | waiting for start
    // FETCH   | instruction read, IR/PC load on mem_ready
    // DECODE  | opcode class decoded and latched
    // ALU     | ALU_CYCLES cycles of execution
    // WB      | ALU result written to register file
    // LDW_MEM | data read, MDR load on mem_ready
    // LDW_WB  | MDR written to register file
    // STW     | data write until mem_ready
    // BR      | branch (BR unconditional, BZ on zero_flag)
    // HALT    | stopped until reset
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ALU, S_WB,
        S_LDW_MEM, S_LDW_WB, S_STW, S_BR, S_HALT
    } state_t;

    localparam int AW = (ALU_CYCLES > 1) ? $clog2(ALU_CYCLES) : 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   alu_cnt_q;
    logic            bz_q;
    logic            illegal_q;
    logic            set_illegal;
    logic [OPW-1:0]  op;
    logic            unused_opcode;

    assign op            = opcode[OPW-1:0];
    assign unused_opcode = ^opcode;
    assign illegal       = illegal_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            alu_cnt_q <= '0;
            bz_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (state_q == S_DECODE) begin
                alu_cnt_q <= AW'(ALU_CYCLES - 1);
                bz_q      <= (op == OPW'(20));
            end else if (state_q == S_ALU && alu_cnt_q != '0) begin
                alu_cnt_q <= alu_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IR_EN       = 1'b0;
        PC_EN       = 1'b0;
        MDR_EN      = 1'b0;
        BR_EN       = 1'b0;
        RFwrite     = 1'b0;
        LDW_EN      = 1'b0;
        dataW_MDR   = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                IR_EN   = mem_ready;
                PC_EN   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op <= OPW'(16))                          state_d = S_ALU;
                else if (op == OPW'(17) || op == OPW'(20))   state_d = S_BR;
                else if (op == OPW'(18))                     state_d = S_STW;
                else if (op == OPW'(19))                     state_d = S_LDW_MEM;
                else if (op == OPW'(21))                     state_d = S_HALT;
                else begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end
            end
            S_ALU: if (alu_cnt_q == '0) state_d = S_WB;
            S_WB: begin
                RFwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_LDW_MEM: begin
                LDW_EN  = 1'b1;
                MemRead = 1'b1;
                MDR_EN  = mem_ready;
                if (mem_ready) state_d = S_LDW_WB;
            end
            S_LDW_WB: begin
                dataW_MDR = 1'b1;
                RFwrite   = 1'b1;
                state_d   = S_FETCH;
            end
            S_STW: begin
                LDW_EN   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BR: begin
                BR_EN   = bz_q ? zero_flag : 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CPU_CTRL_PERF_EN
    logic retire;
    assign retire = (state_q == S_WB) || (state_q == S_LDW_WB) || (state_q == S_BR) ||
                    (state_q == S_STW && mem_ready);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            instr_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
            if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm; expected per-cycle output vectors are hand-computed.
// Output vector bit order: MemRead MemWrite IR_EN PC_EN MDR_EN BR_EN RFwrite LDW_EN dataW_MDR halted illegal.
module tb_cpu_ctrl_fsm;
    logic        CLK;
    logic        resetn;
    logic        start;
    logic        start4;
    logic [15:0] opcode;
    logic        zero_flag;
    logic        mem_ready;

    logic MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN, dataW_MDR, halted, illegal;
    logic [31:0] instr_cnt, cycle_cnt;
    logic MemRead_4, MemWrite_4, IR_EN_4, PC_EN_4, MDR_EN_4, BR_EN_4, RFwrite_4, LDW_EN_4;
    logic dataW_MDR_4, halted_4, illegal_4;
    logic [31:0] unused_instr_cnt_4, unused_cycle_cnt_4;

    int passed = 0;
    int total  = 0;

    cpu_ctrl_fsm dut (
        .CLK(CLK), .resetn(resetn), .start(start), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IR_EN(IR_EN),
        .PC_EN(PC_EN), .MDR_EN(MDR_EN), .BR_EN(BR_EN), .RFwrite(RFwrite), .LDW_EN(LDW_EN),
        .dataW_MDR(dataW_MDR), .halted(halted), .illegal(illegal),
        .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    cpu_ctrl_fsm #(.ALU_CYCLES(4)) dut4 (
        .CLK(CLK), .resetn(resetn), .start(start4), .opcode(opcode), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .MemRead(MemRead_4), .MemWrite(MemWrite_4), .IR_EN(IR_EN_4),
        .PC_EN(PC_EN_4), .MDR_EN(MDR_EN_4), .BR_EN(BR_EN_4), .RFwrite(RFwrite_4),
        .LDW_EN(LDW_EN_4), .dataW_MDR(dataW_MDR_4), .halted(halted_4), .illegal(illegal_4),
        .instr_cnt(unused_instr_cnt_4), .cycle_cnt(unused_cycle_cnt_4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [10:0] outs();
        return {MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN, dataW_MDR,
                halted, illegal};
    endfunction

    function automatic logic [10:0] outs4();
        return {MemRead_4, MemWrite_4, IR_EN_4, PC_EN_4, MDR_EN_4, BR_EN_4, RFwrite_4, LDW_EN_4,
                dataW_MDR_4, halted_4, illegal_4};
    endfunction

    task automatic apply_reset();
        resetn = 1'b0; start = 1'b0; start4 = 1'b0;
        mem_ready = 1'b0; opcode = 16'd0; zero_flag = 1'b0;
        repeat (2) @(posedge CLK);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge CLK);
        total++;
        if (outs() !== 11'h000) $display("FAIL reset_outs got=%h exp=%h", outs(), 11'h000);
        else passed++;
        total++;
        if (outs4() !== 11'h000) $display("FAIL reset_outs4 got=%h exp=%h", outs4(), 11'h000);
        else passed++;
        total++;
        if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", instr_cnt, cycle_cnt);
        else passed++;
        @(posedge CLK); #1;
        @(negedge CLK);
        total++;
        if (outs() !== 11'h000) $display("FAIL idle_hold got=%h exp=%h", outs(), 11'h000);
        else passed++;
        @(posedge CLK); #1;
    endtask

    task automatic test_add();
        logic [10:0] ev [0:5];
        logic [31:0] exp_i, exp_c;
        ev = '{11'h000, 11'h580, 11'h000, 11'h000, 11'h010, 11'h580};
        apply_reset();
        opcode = 16'd0; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            @(negedge CLK);
            total++;
            if (outs() !== ev[i]) $display("FAIL add cyc%0d got=%h exp=%h", i, outs(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
`ifdef CPU_CTRL_PERF_EN
        exp_i = 32'd1; exp_c = 32'd5;
`else
        exp_i = 32'd0; exp_c = 32'd0;
`endif
        total++;
        if (instr_cnt !== exp_i) $display("FAIL add_instr_cnt got=%0d exp=%0d", instr_cnt, exp_i);
        else passed++;
        total++;
        if (cycle_cnt !== exp_c) $display("FAIL add_cycle_cnt got=%0d exp=%0d", cycle_cnt, exp_c);
        else passed++;
    endtask

    task automatic test_ldw_wait();
        logic [10:0] ev [0:8];
        logic        mr [0:8];
        ev = '{11'h000, 11'h580, 11'h000, 11'h408, 11'h408, 11'h408, 11'h448, 11'h014, 11'h580};
        mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        opcode = 16'd19;
        for (int i = 0; i < 9; i++) begin
            start = (i == 0);
            mem_ready = mr[i];
            @(negedge CLK);
            total++;
            if (outs() !== ev[i]) $display("FAIL ldw cyc%0d got=%h exp=%h", i, outs(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_bz();
        logic [10:0] ev [0:7];
        logic [15:0] op [0:7];
        logic        zf [0:7];
        ev = '{11'h000, 11'h580, 11'h000, 11'h000, 11'h580, 11'h000, 11'h020, 11'h580};
        op = '{16'd20, 16'd20, 16'd20, 16'd17, 16'd20, 16'd20, 16'd20, 16'd20};
        zf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            opcode = op[i];
            zero_flag = zf[i];
            @(negedge CLK);
            total++;
            if (outs() !== ev[i]) $display("FAIL bz cyc%0d got=%h exp=%h", i, outs(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_illegal_halt();
        logic [10:0] ev [0:6];
        logic [10:0] eh [0:4];
        ev = '{11'h000, 11'h580, 11'h000, 11'h003, 11'h003, 11'h003, 11'h003};
        eh = '{11'h000, 11'h580, 11'h000, 11'h002, 11'h002};
        apply_reset();
        opcode = 16'd25; mem_ready = 1'b1; start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            start = ~start | (i == 0);
            @(negedge CLK);
            total++;
            if (outs() !== ev[i]) $display("FAIL illegal cyc%0d got=%h exp=%h", i, outs(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
        resetn = 1'b0;
        #1;
        total++;
        if (outs() !== 11'h000) $display("FAIL illegal_reset got=%h exp=%h", outs(), 11'h000);
        else passed++;
        apply_reset();
        opcode = 16'd21; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            @(negedge CLK);
            total++;
            if (outs() !== eh[i]) $display("FAIL halt_op cyc%0d got=%h exp=%h", i, outs(), eh[i]);
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_alu4();
        logic [10:0] ev [0:8];
        ev = '{11'h000, 11'h580, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h010, 11'h580};
        apply_reset();
        opcode = 16'd1; mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start4 = (i == 0);
            @(negedge CLK);
            total++;
            if (outs4() !== ev[i]) $display("FAIL alu4 cyc%0d got=%h exp=%h", i, outs4(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_stw_reset();
        logic [10:0] ev [0:5];
        logic        mr [0:5];
        ev = '{11'h000, 11'h400, 11'h580, 11'h000, 11'h208, 11'h208};
        mr = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        opcode = 16'd18;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            mem_ready = mr[i];
            @(negedge CLK);
            total++;
            if (outs() !== ev[i]) $display("FAIL stw cyc%0d got=%h exp=%h", i, outs(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
        total++;
        if (MemWrite !== 1'b1) $display("FAIL stw_inflight got=%b exp=1", MemWrite);
        else passed++;
        resetn = 1'b0;
        #1;
        total++;
        if (outs() !== 11'h000) $display("FAIL stw_async_reset got=%h exp=%h", outs(), 11'h000);
        else passed++;
        total++;
        if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0)
            $display("FAIL stw_reset_cnt got=%0d/%0d exp=0/0", instr_cnt, cycle_cnt);
        else passed++;
        @(posedge CLK); #1;
        resetn = 1'b1; start = 1'b0;
        @(negedge CLK);
        total++;
        if (outs() !== 11'h000) $display("FAIL stw_post_reset got=%h exp=%h", outs(), 11'h000);
        else passed++;
        @(posedge CLK); #1;
        start = 1'b1;
        @(negedge CLK);
        total++;
        if (outs() !== 11'h000) $display("FAIL stw_idle_start got=%h exp=%h", outs(), 11'h000);
        else passed++;
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        total++;
        if (outs() !== 11'h400) $display("FAIL stw_refetch got=%h exp=%h", outs(), 11'h400);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] ev [0:7];
        logic [15:0] op [0:7];
        logic [31:0] exp_i, exp_c;
        ev = '{11'h000, 11'h580, 11'h000, 11'h208, 11'h580, 11'h000, 11'h020, 11'h580};
        op = '{16'd18, 16'd18, 16'd18, 16'd18, 16'd17, 16'd17, 16'd17, 16'd17};
        apply_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            opcode = op[i];
            @(negedge CLK);
            total++;
            if (outs() !== ev[i]) $display("FAIL b2b cyc%0d got=%h exp=%h", i, outs(), ev[i]);
            else passed++;
            @(posedge CLK); #1;
        end
`ifdef CPU_CTRL_PERF_EN
        exp_i = 32'd2; exp_c = 32'd7;
`else
        exp_i = 32'd0; exp_c = 32'd0;
`endif
        total++;
        if (instr_cnt !== exp_i) $display("FAIL b2b_instr_cnt got=%0d exp=%0d", instr_cnt, exp_i);
        else passed++;
        total++;
        if (cycle_cnt !== exp_c) $display("FAIL b2b_cycle_cnt got=%0d exp=%0d", cycle_cnt, exp_c);
        else passed++;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; start4 = 1'b0;
        opcode = 16'd0; zero_flag = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_ldw_wait();
        test_bz();
        test_illegal_halt();
        test_alu4();
        test_stw_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Parametrised multicycle control unit for the 16-bit CPU datapath. It decodes the opcode field of the instruction register and sequences the PC, IR, MDR, register file and branch enables. It adds three things to the fixed-latency controller: a variable-latency memory handshake, a configurable multi-cycle ALU, and explicit HALT/illegal-opcode handling. It sits between the instruction register and the datapath enable/mux-select inputs.

## Interface
Parameters:
- IW, 16, instruction width; opcode is `opcode[OPW-1:0]`.
- OPW, 5, opcode field width; must be ≥5 and ≤IW.
- ALU_CYCLES, 1, cycles spent in the ALU state; must be ≥1.
- CNT_W, 32, width of the performance counters (only with CPU_CTRL_PERF_EN).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE toward FETCH.
- opcode  in  IW  instruction register contents.
- zero_flag  in  1  ALU zero result, used by BZ.
- mem_ready  in  1  memory completes the current read or write this cycle.
- MemRead, MemWrite  out  1  memory request strobes.
- IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite  out  1  datapath register enables.
- LDW_EN  out  1  memory address mux select (register address instead of PC).
- dataW_MDR  out  1  RF write-data mux select (MDR instead of ALU).
- halted  out  1  core is stopped in HALT.
- illegal  out  1  sticky flag: HALT was entered through an undefined opcode.
- instr_cnt, cycle_cnt  out  CNT_W  retired instructions and non-IDLE cycles (macro only).

## Operation
- Opcodes, taken from `opcode[OPW-1:0]`:
  - 0–16: arithmetic/compare (ADD … EQ).
  - 17: BR.
  - 18: STW.
  - 19: LDW.
  - 20: BZ.
  - 21: HALT.
  - All other values: illegal.
- States: IDLE, FETCH, DECODE, ALU, WB, LDW_MEM, LDW_WB, STW, BR, HALT.
- IDLE: all outputs 0. Moves to FETCH when start=1.
- FETCH:
  - MemRead=1.
  - IR_EN and PC_EN are asserted only in the cycle where mem_ready=1.
  - Moves to DECODE on mem_ready=1; otherwise holds.
- DECODE: all enables 0. Transitions by opcode:
  - arithmetic → ALU
  - LDW → LDW_MEM
  - STW → STW
  - BR or BZ → BR
  - HALT opcode → HALT
  - illegal → HALT, with illegal set to 1
- ALU: all enables 0. Stays exactly ALU_CYCLES cycles, counted by an internal counter, then moves to WB.
- WB: RFwrite=1 for one cycle, then FETCH.
- LDW_MEM:
  - LDW_EN=1 and MemRead=1.
  - MDR_EN=mem_ready.
  - Moves to LDW_WB on mem_ready; otherwise holds.
- LDW_WB: dataW_MDR=1 and RFwrite=1 for one cycle, then FETCH.
- STW:
  - LDW_EN=1 and MemWrite=1, held until mem_ready.
  - Moves to FETCH on the cycle mem_ready=1.
- BR:
  - BR_EN=1 for BR.
  - BR_EN=zero_flag for BZ; the decoded kind is latched in DECODE.
  - Lasts one cycle, then FETCH.
- HALT:
  - halted=1, all enables 0.
  - Leaves only by reset; start is ignored.
- All outputs are a Moore decode of the registered state, except IR_EN, PC_EN and MDR_EN, which are gated by mem_ready.
- The decoded opcode class is registered in DECODE, so opcode changes after DECODE have no effect.

## Timing
- Reset (resetn=0, asynchronous):
  - state=IDLE, ALU counter=0, illegal=0, counters=0.
  - Every output reads 0 immediately after reset asserts, including an in-flight MemRead or MemWrite.
- Release: the first transition can occur on the first CLK edge with resetn=1 and start=1.
- Latency per instruction, with zero memory wait (mem_ready held 1):
  - arithmetic: 3+ALU_CYCLES cycles
  - LDW: 4
  - STW: 3
  - BR/BZ: 3
- Each cycle with mem_ready=0 in FETCH, LDW_MEM or STW adds one cycle.
- mem_ready outside FETCH, LDW_MEM and STW is ignored.
- PC_EN and IR_EN are exactly one cycle per fetch, regardless of wait states.
- mem_ready=1 on the first cycle of a memory state completes the access in that cycle.

## Configuration
- CPU_CTRL_PERF_EN defined:
  - instr_cnt increments on the final cycle of WB, LDW_WB, STW and BR.
  - cycle_cnt increments every cycle the state is not IDLE or HALT.
  - Both counters wrap modulo 2^CNT_W and clear on reset.
- CPU_CTRL_PERF_EN undefined: instr_cnt and cycle_cnt are tied to 0 and no counter flops are built.

## Test plan
- Reset, start, ADD (opcode=0) with mem_ready=1 → state sequence FETCH, DECODE, ALU, WB, FETCH; RFwrite high exactly 1 cycle; PC_EN high 1 cycle.
- LDW (19) with mem_ready low for 3 cycles in LDW_MEM → MemRead held 4 cycles; MDR_EN pulses once on the ready cycle; then dataW_MDR=RFwrite=1 for 1 cycle.
- BZ (20) with zero_flag=0, then again with zero_flag=1 → BR_EN=0 on the first, BR_EN=1 for one cycle on the second.
- Opcode 25 → HALT with illegal=1 and halted=1; start pulses are ignored; resetn=0 clears both flags.
- ALU_CYCLES=4, SUB → 4 cycles in ALU, total latency 7.
- resetn=0 during an STW wait state → MemWrite drops to 0 immediately and state=IDLE; with CPU_CTRL_PERF_EN, instr_cnt and cycle_cnt read 0.
